// File: rtl/audio_dac_tx.sv
// audio_dac_tx: mono I2S transmitter for the board codec DAC.
// Accepts a 32-bit signed tone word through a one-deep valid/ready buffer.
// The word is scaled and saturated to 16 bits, then sent on both channels.
// BCLK and LRCLK are generated from CLK. FRAME_START paces the note sequencer.
module audio_dac_tx #(
    parameter int BCLK_DIV = 8,  // CLK cycles per BCLK half-period, >= 2
    parameter int SHIFT    = 8   // arithmetic right shift before saturation
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] SAMPLE_IN,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    input  logic        CLR_UNDERRUN,
    output logic        FRAME_START,
    output logic        UNDERRUN,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               div_wrap;
    logic               bclk_fall;
    logic               frame_load;
    logic [5:0]         bit_cnt;
    logic [5:0]         bit_next;
    logic [4:0]         slot_pos;
    logic [3:0]         data_idx;
    logic               slot_has_data;
    logic               data_next;
    logic               buf_full;
    logic [15:0]        buf_data;
    logic [15:0]        frame_data;
    logic [15:0]        last_data;
    logic [15:0]        scaled;
    logic               sample_write;
    logic signed [31:0] shifted;

    // The buffer is empty whenever it can take a new sample.
    assign SAMPLE_READY = !buf_full;

    // Timing strobes and the next serial bit, all derived from current state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        div_wrap      = 1'b0;
        bclk_fall     = 1'b0;
        frame_load    = 1'b0;
        bit_next      = 6'd0;
        slot_pos      = 5'd0;
        data_idx      = 4'd0;
        slot_has_data = 1'b0;
        data_next     = 1'b0;
        sample_write  = 1'b0;

        div_wrap      = (div_cnt == DIV_LAST);
        bclk_fall     = div_wrap && AUD_BCLK;
        bit_next      = bit_cnt + 6'd1;
        frame_load    = bclk_fall && (bit_cnt == 6'd63);
        slot_pos      = bit_next[4:0];
        // Slot 1 carries bit 15, slot 16 carries bit 0: MSB one BCLK after LRCLK.
        slot_has_data = (slot_pos >= 5'd1) && (slot_pos <= 5'd16);
        data_idx      = 4'(5'd16 - slot_pos);
        data_next     = slot_has_data ? frame_data[data_idx] : 1'b0;
        sample_write  = SAMPLE_VALID && !buf_full;
    end

    // Scale the incoming word and clamp it into the signed 16-bit range.
    always_comb begin
        shifted = $signed(SAMPLE_IN) >>> SHIFT;
        scaled  = shifted[15:0];
        if (shifted > 32'sd32767) begin
            scaled = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            scaled = 16'h8000;
        end
    end

    // BCLK divider: toggle BCLK each time the counter wraps.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            div_cnt  <= '0;
            AUD_BCLK <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            AUD_BCLK <= !AUD_BCLK;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    // Serial state advances on BCLK falls: bit position, word select, data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bit_cnt     <= 6'd63;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else if (bclk_fall) begin
            bit_cnt     <= bit_next;
            AUD_DACLRCK <= bit_next[5];
            AUD_DACDAT  <= data_next;
        end
    end

    // One-cycle frame-start pulse aligned with the fall that loads a frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= frame_load;
        end
    end

    // Holding buffer and frame load. A load with an empty buffer repeats the
    // last sample; a write landing in that same cycle waits for the next frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            buf_full   <= 1'b0;
            buf_data   <= 16'h0000;
            frame_data <= 16'h0000;
            last_data  <= 16'h0000;
        end else if (frame_load && buf_full) begin
            frame_data <= buf_data;
            last_data  <= buf_data;
            buf_full   <= 1'b0;
        end else begin
            if (frame_load) begin
                frame_data <= last_data;
            end
            if (sample_write) begin
                buf_data <= scaled;
                buf_full <= 1'b1;
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            UNDERRUN <= 1'b0;
        end else if (frame_load && !buf_full) begin
            UNDERRUN <= 1'b1;
        end else if (CLR_UNDERRUN) begin
            UNDERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: randomized scoreboard bench for audio_dac_tx.
// A reference model derives frame timing from the cycle count since reset and
// pushes the expected 16-bit word of every frame; a monitor deserializes the
// I2S stream and pops/compares. Per-cycle timing outputs are also compared.
module tb_audio_dac_tx;

    localparam int D     = 8;
    localparam int SHIFT = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] SAMPLE_IN;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic        CLR_UNDERRUN;
    logic        FRAME_START;
    logic        UNDERRUN;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

    audio_dac_tx #(.BCLK_DIV(D), .SHIFT(SHIFT)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SAMPLE_IN    (SAMPLE_IN),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .CLR_UNDERRUN (CLR_UNDERRUN),
        .FRAME_START  (FRAME_START),
        .UNDERRUN     (UNDERRUN),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT)
    );

    always #5 CLK = !CLK;

    int n_cmp       = 0;
    int n_err       = 0;
    int frames_seen = 0;
    bit chk_en      = 1'b0;

    // Reference model state.
    int          t_cyc  = 0;
    logic        m_bclk = 1'b0;
    logic        m_fs   = 1'b0;
    logic        m_und  = 1'b0;
    logic [15:0] m_last = 16'h0000;
    logic [15:0] pend[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division by 2**SHIFT, then clamp to signed 16 bits.
    function automatic logic [15:0] ref_scale(input logic [31:0] x);
        longint v;
        longint q;
        longint div;
        div = longint'(1) << SHIFT;
        v   = longint'($signed(x));
        q   = v / div;
        if ((v < 0) && ((v % div) != 0)) q = q - 1;
        if (q > 32767) return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    // Model: BCLK toggles every D cycles, falls every 2D cycles, and a frame
    // loads on fall numbers 1, 65, 129, ... counted from reset release.
    initial begin
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) begin
                t_cyc  = 0;
                m_bclk = 1'b0;
                m_fs   = 1'b0;
                m_und  = 1'b0;
                m_last = 16'h0000;
                pend.delete();
                exp_q.delete();
            end else begin
                bit          is_fall;
                bit          load;
                bit          was_empty;
                int          nfall;
                logic [15:0] w;
                t_cyc++;
                m_bclk    = ((t_cyc / D) % 2) == 1;
                is_fall   = (t_cyc % (2 * D)) == 0;
                nfall     = t_cyc / (2 * D);
                load      = is_fall && (((nfall - 1) % 64) == 0);
                m_fs      = load;
                was_empty = (pend.size() == 0);
                if (load) begin
                    if (!was_empty) begin
                        w      = pend.pop_front();
                        m_last = w;
                    end else begin
                        w = m_last;
                    end
                    exp_q.push_back(w);
                end
                if (load && was_empty) m_und = 1'b1;
                else if (CLR_UNDERRUN) m_und = 1'b0;
                if (SAMPLE_VALID && was_empty) pend.push_back(ref_scale(SAMPLE_IN));
            end
        end
    end

    // Per-cycle comparison of timing and handshake outputs against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("bclk",         64'(AUD_BCLK),     64'(m_bclk));
                check("frame_start",  64'(FRAME_START),  64'(m_fs));
                check("sample_ready", 64'(SAMPLE_READY), 64'(pend.size() == 0));
                check("underrun",     64'(UNDERRUN),     64'(m_und));
            end
        end
    end

    // Monitor: on each FRAME_START capture 64 bits at BCLK rises and compare.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET && FRAME_START) begin
                logic [63:0] dat_bits;
                logic [63:0] lr_bits;
                logic [15:0] exp_w;
                logic [15:0] left_w;
                logic [15:0] right_w;
                bit          aborted;
                aborted  = 1'b0;
                dat_bits = '0;
                lr_bits  = '0;
                exp_w    = 16'h0000;
                if (exp_q.size() == 0) begin
                    check("frame_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_w = exp_q.pop_front();
                end
                for (int i = 0; i < 64; i++) begin
                    @(posedge AUD_BCLK or negedge RESET);
                    if (!RESET) begin
                        aborted = 1'b1;
                        break;
                    end
                    @(negedge CLK);
                    if (!RESET) begin
                        aborted = 1'b1;
                        break;
                    end
                    dat_bits[i] = AUD_DACDAT;
                    lr_bits[i]  = AUD_DACLRCK;
                end
                if (!aborted) begin
                    frames_seen++;
                    for (int k = 0; k < 16; k++) begin
                        left_w[15-k]  = dat_bits[1+k];
                        right_w[15-k] = dat_bits[33+k];
                    end
                    check("left_word",  64'(left_w),  64'(exp_w));
                    check("right_word", 64'(right_w), 64'(exp_w));
                    check("zero_pad",   dat_bits & ~64'h0001FFFE_0001FFFE, 64'd0);
                    check("lrck_slots", lr_bits, 64'hFFFFFFFF_00000000);
                end
            end
        end
    end

    task automatic wait_fs(output int cycles);
        cycles = 0;
        while (cycles < 2100) begin
            @(negedge CLK);
            cycles++;
            if (FRAME_START) break;
        end
        if (!FRAME_START) check("frame_start_timeout", 64'(FRAME_START), 64'd1);
    endtask

    task automatic write_sample(input logic [31:0] data);
        int waited;
        waited = 0;
        @(negedge CLK);
        while (!SAMPLE_READY && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        if (!SAMPLE_READY) begin
            check("write_ready_timeout", 64'(SAMPLE_READY), 64'd1);
        end else begin
            SAMPLE_IN    = data;
            SAMPLE_VALID = 1'b1;
            @(posedge CLK);
            #1;
            SAMPLE_VALID = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        CLR_UNDERRUN = 1'b1;
        @(posedge CLK);
        #1;
        CLR_UNDERRUN = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] edges[4];
        edges[0] = 32'h007FFFFF;  // 32767 exactly
        edges[1] = 32'h00800000;  // 32768 -> saturates high
        edges[2] = 32'hFF800000;  // -32768 exactly
        edges[3] = 32'hFF7FFFFF;  // -32769 -> saturates low
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return {{8{1'b0}}, 24'($urandom)} - 32'h00800000;
            default: return edges[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int          cyc;
        int          waited;
        bit          was_ready;
        logic [31:0] a_word;
        logic [31:0] b_word;

        SAMPLE_VALID = 1'b0;
        SAMPLE_IN    = 32'h0;
        CLR_UNDERRUN = 1'b0;
        RESET        = 1'b1;
        #2 RESET     = 1'b0;
        chk_en       = 1'b1;
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;

        // Idle: zero frames, regular frame period, underrun after first frame.
        wait_fs(cyc);
        check("first_fs_cycle", 64'(cyc), 64'd16);
        wait_fs(cyc);
        check("frame_period", 64'(cyc), 64'd1024);
        wait_fs(cyc);
        check("underrun_idle", 64'(UNDERRUN), 64'd1);
        pulse_clr();
        @(negedge CLK);
        check("underrun_cleared", 64'(UNDERRUN), 64'd0);

        // Known word.
        write_sample(32'h00123400);
        wait_fs(cyc);
        wait_fs(cyc);

        // Saturation both ways.
        write_sample(32'h7FFFFFFF);
        write_sample(32'h80000000);
        wait_fs(cyc);
        wait_fs(cyc);

        // Back-pressure: B held valid while the buffer holds A.
        a_word = rand_word();
        b_word = rand_word();
        write_sample(a_word);
        SAMPLE_IN    = b_word;
        SAMPLE_VALID = 1'b1;
        waited       = 0;
        was_ready    = 1'b0;
        while (!was_ready && waited < 3000) begin
            @(negedge CLK);
            was_ready = SAMPLE_READY;
            @(posedge CLK);
            #1;
            waited++;
        end
        SAMPLE_VALID = 1'b0;
        check("backpressure_accept", 64'(was_ready), 64'd1);
        wait_fs(cyc);
        wait_fs(cyc);

        // Underrun repeat, clear, then a write coincident with a load.
        write_sample(32'h000ABC00);
        wait_fs(cyc);
        wait_fs(cyc);
        check("underrun_repeat", 64'(UNDERRUN), 64'd1);
        pulse_clr();
        @(negedge CLK);
        check("underrun_clr_pulse", 64'(UNDERRUN), 64'd0);
        wait_fs(cyc);
        repeat (1023) @(negedge CLK);
        SAMPLE_IN    = rand_word();
        SAMPLE_VALID = 1'b1;
        @(posedge CLK);
        #1;
        SAMPLE_VALID = 1'b0;
        @(negedge CLK);
        check("coincident_fs",       64'(FRAME_START),  64'd1);
        check("coincident_underrun", 64'(UNDERRUN),     64'd1);
        check("coincident_held",     64'(SAMPLE_READY), 64'd0);
        wait_fs(cyc);
        wait_fs(cyc);

        // Randomized traffic with random gaps and clear pulses.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 1200)) @(negedge CLK);
            if ($urandom_range(0, 3) == 0) pulse_clr();
            write_sample(rand_word());
        end
        wait_fs(cyc);
        wait_fs(cyc);

        // Reset in the middle of the right channel.
        wait_fs(cyc);
        repeat (600) @(negedge CLK);
        check("lrck_right_before_reset", 64'(AUD_DACLRCK), 64'd1);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("rst_bclk",   64'(AUD_BCLK),     64'd0);
        check("rst_lrck",   64'(AUD_DACLRCK),  64'd0);
        check("rst_dat",    64'(AUD_DACDAT),   64'd0);
        check("rst_fs",     64'(FRAME_START),  64'd0);
        check("rst_und",    64'(UNDERRUN),     64'd0);
        check("rst_ready",  64'(SAMPLE_READY), 64'd1);
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;
        wait_fs(cyc);
        check("fs_after_reset_cycle", 64'(cyc), 64'd16);
        wait_fs(cyc);
        wait_fs(cyc);

        check("frames_seen_enough", 64'(frames_seen >= 20), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_dac_tx.md
Name: audio_dac_tx

Overview:
- Output end of the synth voice path: takes the 32-bit mixed TONE word from the note datapath and transmits it as I2S serial audio to the board codec DAC.
- Owns a one-sample holding buffer with a valid/ready handshake, saturating scale to 16 bits, BCLK/LRCLK generation, and a frame-start pulse that paces the note sequencer.
- Output is mono: the same sample is sent on left and right.

Parameters:
- BCLK_DIV, 8: CLK cycles per BCLK half-period. At CLK = 50 MHz, BCLK = 3.125 MHz and the frame rate is 48.83 kHz. Legal range is 2 or more.
- SHIFT, 8: right shift applied to the 32-bit input before 16-bit saturation.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- SAMPLE_IN  in  32  signed mixed tone word
- SAMPLE_VALID  in  1  SAMPLE_IN is valid this cycle
- SAMPLE_READY  out  1  holding buffer is empty
- CLR_UNDERRUN  in  1  clears the UNDERRUN flag
- FRAME_START  out  1  one-cycle pulse when a new frame loads
- UNDERRUN  out  1  sticky flag: a frame started with the buffer empty
- AUD_BCLK  out  1  bit clock
- AUD_DACLRCK  out  1  word select: 0 = left, 1 = right
- AUD_DACDAT  out  1  serial data

Behaviour:
- Reset values (RESET low, asynchronous): AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, FRAME_START=0, UNDERRUN=0, SAMPLE_READY=1 (buffer empty). Divider count=0, bit count=63, frame register=0, last-sample register=0.
- Divider: counts 0..BCLK_DIV-1. On the cycle it equals BCLK_DIV-1 it wraps to 0 and AUD_BCLK toggles.
- A "fall" is a toggle from 1 to 0. All serial state changes only on falls.
- On each fall, bit count n goes to (n+1) mod 64. One frame is 64 BCLK periods.
  - AUD_DACLRCK = (n >= 32), registered on the fall.
  - With slot position p = n mod 32: AUD_DACDAT = frame[16-p] for p in 1..16, else 0. This gives I2S framing: MSB one BCLK after the LRCLK edge, left-aligned, zero-padded to 32 slots per channel.
- Frame load, on the fall where n wraps 63 to 0:
  - FRAME_START=1 for exactly that CLK cycle.
  - If the buffer is full: frame = buffer, last = buffer, buffer becomes empty.
  - If the buffer is empty: frame = last and UNDERRUN is set.
  - The load decision uses the buffer state registered before this cycle.
- Scaling, applied on buffer write: v = SAMPLE_IN >>> SHIFT (arithmetic). If v > 32767 the stored value is 16'h7FFF. If v < -32768 it is 16'h8000. Otherwise it is v[15:0].
- Handshake:
  - SAMPLE_READY = buffer empty (registered).
  - A write happens when SAMPLE_VALID & SAMPLE_READY. The buffer becomes full on the next cycle.
  - SAMPLE_VALID while not ready is ignored, with no overwrite.
  - A write in the same cycle as a frame load with an empty buffer: the load underruns (repeats last), and the written sample stays in the buffer for the next frame.
  - A load that empties the buffer raises SAMPLE_READY on the following cycle.
- UNDERRUN clears when CLR_UNDERRUN=1. If a clear and a new underrun happen in the same cycle, the set wins.
- Latency: a sample accepted at least one cycle before a frame load appears with its MSB on AUD_DACDAT exactly one BCLK period after that load's fall.
- The first frame after reset starts on the first fall and transmits 0, flagging UNDERRUN unless a write landed first.
- Reset asserted mid-frame aborts immediately to reset values. The partial frame is not resumed.

Test Plan:
- Reset, hold SAMPLE_VALID=0, BCLK_DIV=8 -> AUD_BCLK period is 16 CLK; FRAME_START every 1024 CLK; AUD_DACDAT all 0; UNDERRUN=1 after the first frame.
- Write SAMPLE_IN=32'h00123400 (SHIFT=8) before a frame -> left and right both shift out 16'h1234 MSB-first, starting one BCLK after each LRCLK edge, then zeros; SAMPLE_READY returns to 1 the cycle after the load.
- Saturation: write 32'h7FFFFFFF, then 32'h80000000 -> frames carry 16'h7FFF and 16'h8000.
- Back-pressure: write A, then hold SAMPLE_VALID with B while SAMPLE_READY=0 -> B is not taken until after A's frame load; frames carry A then B.
- Underrun repeat: write 16'h0ABC-equivalent, supply nothing for the next frame -> second frame repeats 0ABC; UNDERRUN=1; a CLR_UNDERRUN pulse clears it; a write coincident with the load cycle appears one frame later.
- Assert RESET mid-right-channel -> all outputs return to reset values asynchronously; after release, the first fall starts a fresh frame with FRAME_START.
